// File: rtl/voice_scheduler_if.sv
// Request handshake and voice load bus shared between the note source,
// the voice scheduler and the downstream voice demux.
interface voice_scheduler_if #(
  parameter int NOTE_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_on;
  logic [NOTE_W-1:0] req_note;
  logic [2:0]        voice_sel;
  logic              load_en;
  logic              load_gate;
  logic [NOTE_W-1:0] load_note;
  logic              steal;

  modport master (
    output req_valid, req_on, req_note,
    input  req_ready, voice_sel, load_en, load_gate, load_note, steal
  );

  modport slave (
    input  req_valid, req_on, req_note,
    output req_ready, voice_sel, load_en, load_gate, load_note, steal
  );
endinterface

// File: rtl/voice_scheduler.sv
// Allocates note-on/note-off requests onto 8 tone-generator voices with
// retrigger, round-robin allocation, voice stealing and an all-notes-off flush.
module voice_scheduler #(
  parameter int NOTE_W   = 6,
  parameter int N_VOICES = 8
) (
  input  logic             clk,
  input  logic             resetn,
  voice_scheduler_if.slave bus,
  input  logic             all_off,
  output logic [7:0]       voice_busy
);

  typedef enum logic [1:0] {IDLE, SCAN, LOAD, FLUSH} state_t;

  state_t            state, next_state;
  logic [7:0]        busy;
  logic [NOTE_W-1:0] notes [N_VOICES];
  logic [2:0]        alloc_ptr;
  logic [2:0]        flush_idx;
  logic              ready_q;
  logic              req_on_r;
  logic [NOTE_W-1:0] req_note_r;
  logic [2:0]        chosen_q;
  logic              steal_q;
  logic [2:0]        sel_q;
  logic              gate_q;
  logic [NOTE_W-1:0] note_q;

  logic              match_found, free_found;
  logic [2:0]        match_idx, free_idx, vi, cand;

  assign voice_busy    = busy;
  assign bus.req_ready = ready_q;

  // Lowest busy voice holding the requested note, and first free voice from alloc_ptr.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = alloc_ptr;
    vi          = '0;
    cand        = '0;
    for (int unsigned i = 0; i < N_VOICES; i++) begin
      vi = 3'(i);
      if (!match_found && busy[vi] && notes[vi] == req_note_r) begin
        match_found = 1'b1;
        match_idx   = vi;
      end
    end
    for (int unsigned k = 0; k < N_VOICES; k++) begin
      cand = alloc_ptr + 3'(k);
      if (!free_found && !busy[cand]) begin
        free_found = 1'b1;
        free_idx   = cand;
      end
    end
  end

  // Bus fields fall back to the last strobed values when no strobe is issued.
  always_comb begin
    next_state    = state;
    bus.load_en   = 1'b0;
    bus.steal     = 1'b0;
    bus.voice_sel = sel_q;
    bus.load_gate = gate_q;
    bus.load_note = note_q;
    case (state)
      IDLE: begin
        if (all_off)
          next_state = FLUSH;
        else if (bus.req_valid && ready_q)
          next_state = SCAN;
      end
      SCAN: begin
        if (req_on_r || match_found)
          next_state = LOAD;
        else
          next_state = IDLE;
      end
      LOAD: begin
        bus.load_en   = 1'b1;
        bus.voice_sel = chosen_q;
        bus.load_gate = req_on_r;
        bus.load_note = req_note_r;
        bus.steal     = steal_q;
        next_state    = IDLE;
      end
      FLUSH: begin
        if (busy[flush_idx]) begin
          bus.load_en   = 1'b1;
          bus.voice_sel = flush_idx;
          bus.load_gate = 1'b0;
          bus.load_note = notes[flush_idx];
        end
        if (flush_idx == 3'd7)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      busy       <= '0;
      alloc_ptr  <= '0;
      flush_idx  <= '0;
      req_on_r   <= 1'b0;
      req_note_r <= '0;
      chosen_q   <= '0;
      steal_q    <= 1'b0;
      sel_q      <= '0;
      gate_q     <= 1'b0;
      note_q     <= '0;
      for (int unsigned i = 0; i < N_VOICES; i++)
        notes[i] <= '0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == IDLE);
      if (bus.load_en) begin
        sel_q  <= bus.voice_sel;
        gate_q <= bus.load_gate;
        note_q <= bus.load_note;
      end
      case (state)
        IDLE: begin
          flush_idx <= '0;
          if (!all_off && bus.req_valid && ready_q) begin
            req_on_r   <= bus.req_on;
            req_note_r <= bus.req_note;
          end
        end
        SCAN: begin
          steal_q <= 1'b0;
          if (!req_on_r || match_found) begin
            chosen_q <= match_idx;
          end else if (free_found) begin
            chosen_q  <= free_idx;
            alloc_ptr <= free_idx + 3'd1;
          end else begin
            chosen_q  <= alloc_ptr;
            steal_q   <= 1'b1;
            alloc_ptr <= alloc_ptr + 3'd1;
          end
        end
        LOAD: begin
          if (req_on_r) begin
            busy[chosen_q]  <= 1'b1;
            notes[chosen_q] <= req_note_r;
          end else begin
            busy[chosen_q] <= 1'b0;
          end
        end
        FLUSH: begin
          busy[flush_idx] <= 1'b0;
          flush_idx       <= flush_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a voice-pool model predicts each strobe,
// a negedge monitor pops and compares every load strobe the DUT issues.
module tb_voice_scheduler;
  localparam int NOTE_W = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       all_off = 1'b0;
  logic [7:0] voice_busy;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int cyc;
    int sel;
    int gate;
    int note;
    int steal;
  } exp_t;

  exp_t sbq[$];
  int   mbusy[8];
  int   mnote[8];
  int   mptr;

  voice_scheduler_if #(.NOTE_W(NOTE_W)) bus();

  voice_scheduler #(.NOTE_W(NOTE_W), .N_VOICES(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus.slave),
    .all_off    (all_off),
    .voice_busy (voice_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mword();
    int w = 0;
    for (int i = 0; i < 8; i++)
      if (mbusy[i] != 0) w |= (1 << i);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mbusy[i] = 0;
      mnote[i] = 0;
    end
    mptr = 0;
  endtask

  // Voice pool rules: retrigger lowest match, else first free from pointer, else steal.
  task automatic model_req(input bit on, input int n, input int a, output int ready_at);
    exp_t e;
    int v  = -1;
    int st = 0;
    for (int i = 0; i < 8; i++)
      if (v < 0 && mbusy[i] != 0 && mnote[i] == n) v = i;
    if (on) begin
      if (v < 0) begin
        for (int k = 0; k < 8; k++)
          if (v < 0 && mbusy[(mptr + k) % 8] == 0) v = (mptr + k) % 8;
        if (v < 0) begin
          v  = mptr;
          st = 1;
        end
        mptr = (v + 1) % 8;
      end
      mbusy[v] = 1;
      mnote[v] = n;
    end else if (v >= 0) begin
      mbusy[v] = 0;
    end
    if (v < 0) begin
      ready_at = a + 1;
    end else begin
      e.cyc = a + 1; e.sel = v; e.gate = on; e.note = n; e.steal = st;
      sbq.push_back(e);
      ready_at = a + 2;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input bit on, input int n);
    int a;
    int ready_at;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_on    = on;
    bus.req_note  = NOTE_W'(n);
    @(posedge clk);
    #1;
    a = cyc;
    bus.req_valid = 1'b0;
    model_req(on, n, a, ready_at);
    for (int c = a; c <= ready_at; c++) begin
      @(negedge clk);
      chk("ready_req", bus.req_ready, (c == ready_at));
    end
    chk("busy_req", voice_busy, mword());
  endtask

  task automatic do_flush(input bit with_req);
    int   f;
    exp_t e;
    wait_ready();
    all_off = 1'b1;
    if (with_req) begin
      bus.req_valid = 1'b1;
      bus.req_on    = 1'b1;
      bus.req_note  = NOTE_W'(63);
    end
    @(posedge clk);
    #1;
    f = cyc;
    all_off = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mbusy[i] != 0) begin
        e.cyc = f + i; e.sel = i; e.gate = 0; e.note = mnote[i]; e.steal = 0;
        sbq.push_back(e);
      end
      mbusy[i] = 0;
    end
    for (int c = f; c <= f + 8; c++) begin
      @(negedge clk);
      chk("ready_flush", bus.req_ready, (c == f + 8));
      all_off = (c == f + 2);
    end
    all_off = 1'b0;
    chk("busy_flush", voice_busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.load_en) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got sel=%0d gate=%0d note=%0d expected none (cycle %0d)",
                 bus.voice_sel, bus.load_gate, bus.load_note, cyc);
      end else begin
        e = sbq.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("voice_sel", bus.voice_sel, e.sel);
        chk("load_gate", bus.load_gate, e.gate);
        chk("load_note", bus.load_note, e.note);
        chk("steal", bus.steal, e.steal);
      end
    end else begin
      chk("steal_idle", bus.steal, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_on    = 1'b0;
    bus.req_note  = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_load_en", bus.load_en, 0);
    chk("rst_sel", bus.voice_sel, 0);
    chk("rst_gate", bus.load_gate, 0);
    chk("rst_note", bus.load_note, 0);
    chk("rst_steal", bus.steal, 0);
    chk("rst_busy", voice_busy, 0);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1);

    do_req(1, 10);
    do_req(1, 20);
    do_req(1, 30);
    chk("busy_three_on", voice_busy, 8'h07);
    do_req(0, 20);
    chk("busy_off20", voice_busy, 8'h05);
    do_req(0, 50);
    do_req(1, 10);
    do_req(1, 11);
    chk("busy_ptr_kept", voice_busy, 8'h0D);

    do_flush(0);
    model_reset();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int n = 1; n <= 8; n++) do_req(1, n);
    chk("busy_full", voice_busy, 8'hFF);
    do_req(1, 40);
    do_req(1, 41);

    do_flush(0);
    for (int n = 50; n <= 57; n++) do_req(1, n);
    do_req(0, 57);
    do_req(0, 51);
    do_req(0, 52);
    do_req(0, 54);
    chk("busy_a5", voice_busy, 8'hA5);
    do_flush(1);

    // Reset asserted during the scan cycle must abandon the load.
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_on    = 1'b1;
    bus.req_note  = NOTE_W'(33);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_load_en", bus.load_en, 0);
    chk("midrst_sel", bus.voice_sel, 0);
    chk("midrst_gate", bus.load_gate, 0);
    chk("midrst_note", bus.load_note, 0);
    chk("midrst_busy", voice_busy, 0);
    chk("midrst_ready", bus.req_ready, 0);
    resetn = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_after", bus.req_ready, 1);

    for (int t = 0; t < 200; t++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6)
        do_flush(bit'($urandom_range(0, 1)));
      else
        do_req($urandom_range(0, 99) < 65, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
